arch_map_table_n: RTL and testbench

Parametrised architectural map table (AMT) for the retire stage. It holds the committed logical-to-physical register mapping and accepts up to COMMIT_WIDTH retiring destinations per cycle. For each retiring destination it returns the displaced physical register to the free list. On a flush, a recovery FSM streams the whole table to the rename map table, RECOVER_WIDTH entries per cycle, with valid, busy and done handshakes.

---
 rtl/arch_map_table_n_if.sv | 32 +++
 rtl/arch_map_table_n.sv | 160 ++++++++++++++++
 tb/tb_arch_map_table_n.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arch_map_table_n_if.sv
// Retire/recovery bus of the architectural map table.
// The master drives commits and the recover request; the slave (the AMT) returns releases and the recovery stream.
interface arch_map_table_n_if #(
  parameter int COMMIT_WIDTH  = 4,
  parameter int LOG_W         = 5,
  parameter int PHYS_W        = 7,
  parameter int RECOVER_WIDTH = 4
);
  localparam int PKT_W = LOG_W + PHYS_W;

  logic [COMMIT_WIDTH-1:0]        commit_valid_i;
  logic [COMMIT_WIDTH*PKT_W-1:0]  commit_packet_i;
  logic                           recover_flag_i;
  logic [COMMIT_WIDTH-1:0]        released_valid_o;
  logic [COMMIT_WIDTH*PHYS_W-1:0] released_phys_o;
  logic                           recover_valid_o;
  logic [RECOVER_WIDTH*PKT_W-1:0] recover_packet_o;
  logic                           recover_busy_o;
  logic                           recover_done_o;

  modport master (
    output commit_valid_i, commit_packet_i, recover_flag_i,
    input  released_valid_o, released_phys_o, recover_valid_o,
    input  recover_packet_o, recover_busy_o, recover_done_o
  );

  modport slave (
    input  commit_valid_i, commit_packet_i, recover_flag_i,
    output released_valid_o, released_phys_o, recover_valid_o,
    output recover_packet_o, recover_busy_o, recover_done_o
  );
endinterface

// File: rtl/arch_map_table_n.sv
// Architectural map table: committed logical->physical map, per-lane release of displaced tags,
// and a recovery walk streaming the table out. Optional perf counters under `AMT_PERF_EN.
module arch_map_table_n #(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG       = 32,
  parameter int LOG_W         = 5,
  parameter int PHYS_W        = 7,
  parameter int RECOVER_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  arch_map_table_n_if.slave   bus
`ifdef AMT_PERF_EN
  ,
  output logic [31:0]         perf_writes_o,
  output logic [15:0]         perf_recoveries_o
`endif
);
  localparam int PKT_W = LOG_W + PHYS_W;

  typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_e;

  state_e                          state_q, state_d;
  logic [LOG_W-1:0]                cnt_q, cnt_d;
  logic [PHYS_W-1:0]               table_q [NUM_LOG];
  logic [PHYS_W-1:0]               table_d [NUM_LOG];
  logic [COMMIT_WIDTH-1:0]         rel_valid_q, rel_valid_d;
  logic [COMMIT_WIDTH*PHYS_W-1:0]  rel_phys_q, rel_phys_d;

  logic                            busy;
  logic                            walk_start;
  logic [COMMIT_WIDTH-1:0]         lane_en, shadowed, wr_en;
  logic [LOG_W-1:0]                lane_log  [COMMIT_WIDTH];
  logic [PHYS_W-1:0]               lane_phys [COMMIT_WIDTH];
  logic [LOG_W-1:0]                walk_idx  [RECOVER_WIDTH];
  logic                            rec_valid, rec_done;
  logic [RECOVER_WIDTH*PKT_W-1:0]  rec_packet;

  // Commits are blocked while the table is being streamed out.
  always_comb begin
    busy = (state_q != ST_IDLE);
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      lane_log[k]  = bus.commit_packet_i[k*PKT_W+PHYS_W +: LOG_W];
      lane_phys[k] = bus.commit_packet_i[k*PKT_W +: PHYS_W];
      lane_en[k]   = bus.commit_valid_i[k] & ~busy;
    end
  end

  // A lane overwritten by a younger lane of the same group never reaches the table.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      shadowed[k] = 1'b0;
      for (int m = k + 1; m < COMMIT_WIDTH; m++) begin
        if (lane_en[m] && (lane_log[m] == lane_log[k])) shadowed[k] = 1'b1;
      end
    end
    wr_en = lane_en & ~shadowed;
  end

  always_comb begin
    rel_valid_d = lane_en;
    rel_phys_d  = '0;
    table_d     = table_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (lane_en[k]) begin
        rel_phys_d[k*PHYS_W +: PHYS_W] = shadowed[k] ? lane_phys[k] : table_q[lane_log[k]];
      end
      if (wr_en[k]) table_d[lane_log[k]] = lane_phys[k];
    end
  end

  always_comb begin
    for (int j = 0; j < RECOVER_WIDTH; j++) begin
      walk_idx[j] = cnt_q + LOG_W'(j);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rec_valid  = 1'b0;
    rec_done   = 1'b0;
    rec_packet = '0;
    walk_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.recover_flag_i) begin
          walk_start = 1'b1;
          state_d    = ST_WALK;
          cnt_d      = '0;
        end
      end
      ST_WALK: begin
        rec_valid = 1'b1;
        for (int j = 0; j < RECOVER_WIDTH; j++) begin
          rec_packet[j*PKT_W +: PKT_W] = {walk_idx[j], table_q[walk_idx[j]]};
        end
        if (cnt_q == LOG_W'(NUM_LOG - RECOVER_WIDTH)) state_d = ST_DONE;
        else cnt_d = cnt_q + LOG_W'(RECOVER_WIDTH);
      end
      ST_DONE: begin
        rec_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rel_valid_q <= '0;
      rel_phys_q  <= '0;
      for (int i = 0; i < NUM_LOG; i++) table_q[i] <= PHYS_W'(i);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rel_valid_q <= rel_valid_d;
      rel_phys_q  <= rel_phys_d;
      for (int i = 0; i < NUM_LOG; i++) table_q[i] <= table_d[i];
    end
  end

  assign bus.released_valid_o = rel_valid_q;
  assign bus.released_phys_o  = rel_phys_q;
  assign bus.recover_valid_o  = rec_valid;
  assign bus.recover_packet_o = rec_packet;
  assign bus.recover_busy_o   = busy;
  assign bus.recover_done_o   = rec_done;

  a_no_commit_while_busy: assert property (
    @(posedge clk) disable iff (!reset) !(busy && (|bus.commit_valid_i)));

`ifdef AMT_PERF_EN
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [15:0] perf_rec_q, perf_rec_d;
  logic [32:0] writes_sum;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    writes_sum    = {1'b0, perf_writes_q} + 33'($countones(wr_en));
    perf_writes_d = writes_sum[32] ? '1 : writes_sum[31:0];
    perf_rec_d    = (walk_start && (perf_rec_q != '1)) ? perf_rec_q + 16'd1 : perf_rec_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_writes_q <= '0;
      perf_rec_q    <= '0;
    end else begin
      perf_writes_q <= perf_writes_d;
      perf_rec_q    <= perf_rec_d;
    end
  end

  assign perf_writes_o     = perf_writes_q;
  assign perf_recoveries_o = perf_rec_q;
`endif
endmodule

// File: tb/tb_arch_map_table_n.sv
// Scoreboard bench for arch_map_table_n: a reference table and walk-phase model predict releases
// and recovery beats, which are queued at stimulus time and popped when the DUT responds.
module tb_arch_map_table_n;
  localparam int CW = 4, NL = 32, LW = 5, PW = 7, RW = 4, KW = LW + PW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arch_map_table_n_if #(.COMMIT_WIDTH(CW), .LOG_W(LW), .PHYS_W(PW), .RECOVER_WIDTH(RW)) bus ();

`ifdef AMT_PERF_EN
  logic [31:0] perf_writes;
  logic [15:0] perf_recoveries;
  int          m_writes = 0;
  int          m_starts = 0;
`endif

  arch_map_table_n #(.COMMIT_WIDTH(CW), .NUM_LOG(NL), .LOG_W(LW), .PHYS_W(PW), .RECOVER_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef AMT_PERF_EN
    ,
    .perf_writes_o     (perf_writes),
    .perf_recoveries_o (perf_recoveries)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_beats = 0;
  int n_done  = 0;

  logic [PW-1:0]      m_tab [NL];
  int                 m_phase;
  logic [CW*PW+CW-1:0] rel_q [$];
  logic [RW*KW-1:0]   beat_q [$];
  logic [RW*KW-1:0]   seen_beat [NL/RW];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] pk(input int lg, input int ph);
    return {LW'(lg), PW'(ph)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_tab[i] = PW'(i);
    m_phase = 0;
    beat_q.delete();
    rel_q.delete();
  endtask

  // One clock: predict, advance, then compare everything the DUT shows in the new cycle.
  task automatic step();
    logic [CW-1:0]    act;
    logic [CW*PW-1:0] exp_p;
    logic [LW-1:0]    lg [CW];
    logic [PW-1:0]    ph [CW];
    logic [PW-1:0]    nt [NL];
    logic [CW*PW+CW-1:0] e;
    logic [RW*KW-1:0] b;
    bit               sh;
    int               nphase;
    act   = bus.commit_valid_i & {CW{m_phase == 0}};
    exp_p = '0;
    for (int k = 0; k < CW; k++) begin
      lg[k] = bus.commit_packet_i[k*KW+PW +: LW];
      ph[k] = bus.commit_packet_i[k*KW +: PW];
    end
    for (int k = 0; k < CW; k++) begin
      if (act[k]) begin
        sh = 1'b0;
        for (int m = k + 1; m < CW; m++) if (act[m] && lg[m] == lg[k]) sh = 1'b1;
        exp_p[k*PW +: PW] = sh ? ph[k] : m_tab[lg[k]];
      end
    end
    nt = m_tab;
    for (int k = 0; k < CW; k++) if (act[k]) nt[lg[k]] = ph[k];
`ifdef AMT_PERF_EN
    for (int i = 0; i < NL; i++) if (nt[i] != m_tab[i] || 1'b1) ;
    for (int k = 0; k < CW; k++) begin
      sh = 1'b0;
      for (int m = k + 1; m < CW; m++) if (act[m] && lg[m] == lg[k]) sh = 1'b1;
      if (act[k] && !sh) m_writes++;
    end
`endif
    rel_q.push_back({act, exp_p});
    nphase = 0;
    if (m_phase == 0 && bus.recover_flag_i) begin
      nphase = 1;
`ifdef AMT_PERF_EN
      m_starts++;
`endif
      for (int bt = 0; bt < NL / RW; bt++) begin
        b = '0;
        for (int j = 0; j < RW; j++) b[j*KW +: KW] = {LW'(bt*RW + j), nt[bt*RW + j]};
        beat_q.push_back(b);
      end
    end else if (m_phase >= 1 && m_phase <= NL / RW) begin
      nphase = m_phase + 1;
    end
    @(posedge clk);
    #1;
    m_tab   = nt;
    m_phase = nphase;
    e = rel_q.pop_front();
    chk("rel_valid", 64'(bus.released_valid_o), 64'(e[CW*PW +: CW]));
    chk("rel_phys", 64'(bus.released_phys_o), 64'(e[CW*PW-1:0]));
    chk("rec_valid", 64'(bus.recover_valid_o), 64'(m_phase >= 1 && m_phase <= NL / RW));
    chk("rec_busy", 64'(bus.recover_busy_o), 64'(m_phase != 0));
    chk("rec_done", 64'(bus.recover_done_o), 64'(m_phase == NL / RW + 1));
    if (bus.recover_valid_o) begin
      n_beats++;
      chk("beat_avail", 64'(beat_q.size() != 0), 64'(1));
      if (beat_q.size() != 0) begin
        b = beat_q.pop_front();
        chk("beat", 64'(bus.recover_packet_o), 64'(b));
        if (m_phase >= 1 && m_phase <= NL / RW) seen_beat[m_phase-1] = bus.recover_packet_o;
      end
    end
    if (bus.recover_done_o) n_done++;
  endtask

  task automatic run_walk(input string tag);
    int b0, d0;
    b0 = n_beats;
    d0 = n_done;
    bus.recover_flag_i = 1'b1;
    step();
    bus.recover_flag_i = 1'b0;
    repeat (NL / RW + 1) step();
    chk({tag, "_beats"}, 64'(n_beats - b0), 64'(NL / RW));
    chk({tag, "_done"}, 64'(n_done - d0), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"}, 64'(bus.released_valid_o), 64'(0));
    chk({tag, "_rp"}, 64'(bus.released_phys_o), 64'(0));
    chk({tag, "_valid"}, 64'(bus.recover_valid_o), 64'(0));
    chk({tag, "_pkt"}, 64'(bus.recover_packet_o), 64'(0));
    chk({tag, "_busy"}, 64'(bus.recover_busy_o), 64'(0));
    chk({tag, "_done"}, 64'(bus.recover_done_o), 64'(0));
  endtask

  initial begin
    int b0, d0;
    reset               = 1'b0;
    bus.commit_valid_i  = '0;
    bus.commit_packet_i = '0;
    bus.recover_flag_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    repeat (2) step();
    run_walk("ident");
    chk("ident_beat7", 64'(seen_beat[7]), 64'({pk(31, 31), pk(30, 30), pk(29, 29), pk(28, 28)}));

    // Lane 0 shadowed by lane 1 on r5; lane 3 idle.
    bus.commit_valid_i  = 4'b0111;
    bus.commit_packet_i = {pk(0, 0), pk(3, 42), pk(5, 41), pk(5, 40)};
    step();
    chk("r5_rel_v", 64'(bus.released_valid_o), 64'(4'b0111));
    chk("r5_rel_p", 64'(bus.released_phys_o), 64'({7'd0, 7'd3, 7'd5, 7'd40}));
    bus.commit_valid_i  = '0;
    bus.commit_packet_i = '0;
    step();
    run_walk("w5");
    chk("w5_beat0", 64'(seen_beat[0]), 64'({pk(3, 42), pk(2, 2), pk(1, 1), pk(0, 0)}));
    chk("w5_beat1", 64'(seen_beat[1]), 64'({pk(7, 7), pk(6, 6), pk(5, 41), pk(4, 4)}));

    // All four lanes on r9.
    bus.commit_valid_i  = 4'b1111;
    bus.commit_packet_i = {pk(9, 53), pk(9, 52), pk(9, 51), pk(9, 50)};
    step();
    chk("r9_rel_p", 64'(bus.released_phys_o), 64'({7'd9, 7'd52, 7'd51, 7'd50}));
    bus.commit_valid_i  = '0;
    bus.commit_packet_i = '0;

    // Held request: one walk, DONE, then a second walk starting right after.
    b0 = n_beats;
    d0 = n_done;
    bus.recover_flag_i = 1'b1;
    repeat (12) step();
    bus.recover_flag_i = 1'b0;
    repeat (8) step();
    chk("held_beats", 64'(n_beats - b0), 64'(2 * NL / RW));
    chk("held_done", 64'(n_done - d0), 64'(2));
    chk("r9_beat2", 64'(seen_beat[2]), 64'({pk(11, 11), pk(10, 10), pk(9, 53), pk(8, 8)}));

    // Reset in the middle of beat 3.
    bus.recover_flag_i = 1'b1;
    step();
    bus.recover_flag_i = 1'b0;
    repeat (3) step();
    chk("pre_abort_valid", 64'(bus.recover_valid_o), 64'(1));
    reset = 1'b0;
    #1;
    chk_all_zero("abort");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    run_walk("post");
    chk("post_beat0", 64'(seen_beat[0]), 64'({pk(3, 3), pk(2, 2), pk(1, 1), pk(0, 0)}));
    chk("post_beat2", 64'(seen_beat[2]), 64'({pk(11, 11), pk(10, 10), pk(9, 9), pk(8, 8)}));

`ifdef AMT_PERF_EN
    chk("perf_rec", 64'(perf_recoveries), 64'(1));
    chk("perf_wr", 64'(perf_writes), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
